// File: rtl/bbcore_ctrl_pkg.sv
// Shared constants for the BitBlade job sequencer: state encoding,
// precision codes and the default psum geometry.
package bbcore_ctrl_pkg;

    localparam int BITS_PSUM   = 16;
    localparam int PE_ARRAY    = 4;
    localparam int PSUM_W_DEF  = BITS_PSUM * PE_ARRAY;
    localparam int TIMEOUT_DEF = 1024;

    // Precision codes understood by the core's i_Precision / w_Precision
    localparam logic [1:0] PREC_2B = 2'b00;
    localparam logic [1:0] PREC_4B = 2'b01;
    localparam logic [1:0] PREC_8B = 2'b10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_OUT   = 3'd5;

endpackage

// File: rtl/bbcore_ctrl_if.sv
// Job descriptor and result channels between the tile scheduler / writeback
// (master side) and the sequencer (slave side).
interface bbcore_ctrl_if
    import bbcore_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10,
    parameter int PSUM_W = PSUM_W_DEF
);
    logic              job_vld;
    logic              job_rdy;
    logic [LEN_W-1:0]  job_len;
    logic [ADDR_W-1:0] job_act_base;
    logic [ADDR_W-1:0] job_wgt_base;
    logic [1:0]        job_i_prec;
    logic [1:0]        job_w_prec;
    logic              job_use_bias;

    logic              res_vld;
    logic              res_rdy;
    logic [PSUM_W-1:0] res_psum;
    logic              res_err;

    modport master (
        output job_vld, job_len, job_act_base, job_wgt_base,
               job_i_prec, job_w_prec, job_use_bias, res_rdy,
        input  job_rdy, res_vld, res_psum, res_err
    );

    modport slave (
        input  job_vld, job_len, job_act_base, job_wgt_base,
               job_i_prec, job_w_prec, job_use_bias, res_rdy,
        output job_rdy, res_vld, res_psum, res_err
    );

endinterface

// File: rtl/bbcore_step_gen.sv
// Step counter and buffer address generator; core_vld/sel_bias trail the
// read strobe by one cycle to cover the fixed buffer read latency.
module bbcore_step_gen
    import bbcore_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] act_base,
    input  logic [ADDR_W-1:0] wgt_base,
    input  logic              use_bias,
    output logic              act_rd_en,
    output logic [ADDR_W-1:0] act_rd_addr,
    output logic              wgt_rd_en,
    output logic [ADDR_W-1:0] wgt_rd_addr,
    output logic              core_vld,
    output logic              core_sel_bias,
    output logic              last_step
);

    logic             rd_en;
    logic [LEN_W-1:0] step;
    logic             bias_pend;

    assign act_rd_en = rd_en;
    assign wgt_rd_en = rd_en;
    assign last_step = rd_en && (step == len - LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en         <= 1'b0;
            step          <= '0;
            bias_pend     <= 1'b0;
            act_rd_addr   <= '0;
            wgt_rd_addr   <= '0;
            core_vld      <= 1'b0;
            core_sel_bias <= 1'b0;
        end else begin
            core_vld      <= rd_en;
            core_sel_bias <= rd_en & bias_pend;
            if (start) begin
                rd_en       <= 1'b1;
                step        <= '0;
                bias_pend   <= use_bias;
                act_rd_addr <= act_base;
                wgt_rd_addr <= wgt_base;
            end else if (rd_en) begin
                // Bias applies to the first read only; addresses wrap silently
                bias_pend <= 1'b0;
                if (last_step) begin
                    rd_en <= 1'b0;
                end else begin
                    step        <= step + LEN_W'(1);
                    act_rd_addr <= act_rd_addr + ADDR_W'(1);
                    wgt_rd_addr <= wgt_rd_addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bbcore_ctrl.sv
// BitBlade job sequencer: accepts a job, streams buffer reads into the core,
// flushes, waits for o_Done (with timeout) and holds the psum for writeback.
module bbcore_ctrl
    import bbcore_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 10,
    parameter int PSUM_W  = PSUM_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    bbcore_ctrl_if.slave      bus,
    output logic              act_rd_en,
    output logic [ADDR_W-1:0] act_rd_addr,
    output logic              wgt_rd_en,
    output logic [ADDR_W-1:0] wgt_rd_addr,
    output logic              core_vld,
    output logic              core_sel_bias,
    output logic              core_flush,
    output logic [1:0]        core_i_prec,
    output logic [1:0]        core_w_prec,
    input  logic              core_done,
    input  logic [PSUM_W-1:0] core_psum,
    output logic              busy
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [LEN_W-1:0]  len_r;
    logic [TW-1:0]     tmo_cnt;
    logic              res_vld;
    logic              res_err;
    logic [PSUM_W-1:0] res_psum;
    logic              accept;
    logic              start;
    logic              last_step;

    assign accept      = (state == ST_IDLE) && bus.job_vld;
    assign start       = accept && (bus.job_len != '0);
    assign bus.job_rdy = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign bus.res_vld  = res_vld;
    assign bus.res_err  = res_err;
    assign bus.res_psum = res_psum;

    bbcore_step_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_step (
        .clk           (CLK),
        .rst_n         (RST),
        .start         (start),
        .len           (len_r),
        .act_base      (bus.job_act_base),
        .wgt_base      (bus.job_wgt_base),
        .use_bias      (bus.job_use_bias),
        .act_rd_en     (act_rd_en),
        .act_rd_addr   (act_rd_addr),
        .wgt_rd_en     (wgt_rd_en),
        .wgt_rd_addr   (wgt_rd_addr),
        .core_vld      (core_vld),
        .core_sel_bias (core_sel_bias),
        .last_step     (last_step)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (bus.job_vld) state_nx = (bus.job_len == '0) ? ST_OUT : ST_RUN;
            ST_RUN:   if (last_step) state_nx = ST_DRAIN;
            ST_DRAIN: state_nx = ST_FLUSH;
            ST_FLUSH: state_nx = ST_WAIT;
            ST_WAIT:  if (core_done || tmo_cnt == TMO_LAST) state_nx = ST_OUT;
            ST_OUT:   if (bus.res_rdy) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Flush and result-valid are registered from the next state so they
    // line up exactly with the FLUSH and OUT cycles.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= ST_IDLE;
            len_r       <= '0;
            core_i_prec <= PREC_2B;
            core_w_prec <= PREC_2B;
            tmo_cnt     <= '0;
            core_flush  <= 1'b0;
            res_vld     <= 1'b0;
            res_err     <= 1'b0;
            res_psum    <= '0;
        end else begin
            state      <= state_nx;
            core_flush <= (state_nx == ST_FLUSH);
            res_vld    <= (state_nx == ST_OUT);

            if (accept) begin
                len_r       <= bus.job_len;
                core_i_prec <= bus.job_i_prec;
                core_w_prec <= bus.job_w_prec;
                if (bus.job_len == '0) begin
                    res_psum <= '0;
                    res_err  <= 1'b1;
                end
            end

            if (state == ST_FLUSH) begin
                tmo_cnt <= '0;
            end else if (state == ST_WAIT) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            // A done arriving on the last allowed cycle still wins over timeout
            if (state == ST_WAIT) begin
                if (core_done) begin
                    res_psum <= core_psum;
                    res_err  <= 1'b0;
                end else if (tmo_cnt == TMO_LAST) begin
                    res_psum <= '0;
                    res_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bbcore_ctrl.sv
// Table-driven bench for bbcore_ctrl with a result scoreboard and
// hand-written reset-abort sequence.
module tb_bbcore_ctrl;
    import bbcore_ctrl_pkg::*;

    localparam int ADDR_W = 10;
    localparam int LEN_W  = 10;
    localparam int PSUM_W = PSUM_W_DEF;
    localparam int TMO    = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bbcore_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .PSUM_W(PSUM_W)) bus ();

    logic              act_rd_en, wgt_rd_en;
    logic [ADDR_W-1:0] act_rd_addr, wgt_rd_addr;
    logic              core_vld, core_sel_bias, core_flush;
    logic [1:0]        core_i_prec, core_w_prec;
    logic              core_done;
    logic [PSUM_W-1:0] core_psum;
    logic              busy;

    bbcore_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .PSUM_W(PSUM_W), .TIMEOUT(TMO)) dut (
        .CLK(clk), .RST(rst_n), .bus(bus),
        .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
        .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr),
        .core_vld(core_vld), .core_sel_bias(core_sel_bias), .core_flush(core_flush),
        .core_i_prec(core_i_prec), .core_w_prec(core_w_prec),
        .core_done(core_done), .core_psum(core_psum), .busy(busy)
    );

    typedef struct {
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] act_base;
        logic [ADDR_W-1:0] wgt_base;
        logic [1:0]        i_prec;
        logic [1:0]        w_prec;
        logic              use_bias;
        int                done_dly;
        logic [PSUM_W-1:0] psum;
        int                hold;
        bit                poke;
        logic              exp_err;
        logic [PSUM_W-1:0] exp_psum;
    } job_t;

    typedef struct {
        logic [PSUM_W-1:0] psum;
        logic              err;
    } res_t;

    res_t sb_q[$];
    res_t sb_exp;
    job_t jobs[8];
    int   errors = 0;
    int   checks = 0;

    task automatic check_output(input string name, input logic [PSUM_W-1:0] act,
                                input logic [PSUM_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic job_t mk(input int len, input int ab, input int wb, input logic [1:0] ip,
                                input logic [1:0] wp, input logic ub, input int dly,
                                input logic [PSUM_W-1:0] ps, input int hold, input bit poke,
                                input logic eerr, input logic [PSUM_W-1:0] eps);
        job_t j;
        j.len = LEN_W'(len); j.act_base = ADDR_W'(ab); j.wgt_base = ADDR_W'(wb);
        j.i_prec = ip; j.w_prec = wp; j.use_bias = ub; j.done_dly = dly; j.psum = ps;
        j.hold = hold; j.poke = poke; j.exp_err = eerr; j.exp_psum = eps;
        return j;
    endfunction

    // Result scoreboard: pops one expectation per completed result handshake
    always begin
        @(negedge clk);
        #1;
        if (rst_n && bus.res_vld && bus.res_rdy) begin
            if (sb_q.size() == 0) begin
                check_output("sb_unexpected_result", 1, 0);
            end else begin
                sb_exp = sb_q.pop_front();
                check_output("sb_psum", bus.res_psum, sb_exp.psum);
                check_output("sb_err", PSUM_W'(bus.res_err), PSUM_W'(sb_exp.err));
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check_output({tag, "_zero_outs"},
                     PSUM_W'({act_rd_en, wgt_rd_en, act_rd_addr, wgt_rd_addr, core_vld,
                              core_sel_bias, core_flush, core_i_prec, core_w_prec,
                              bus.res_vld, bus.res_err, busy}), '0);
        check_output({tag, "_res_psum"}, bus.res_psum, '0);
        check_output({tag, "_job_rdy"}, PSUM_W'(bus.job_rdy), 1);
    endtask

    task automatic drive_job(input job_t j);
        bus.job_len      = j.len;
        bus.job_act_base = j.act_base;
        bus.job_wgt_base = j.wgt_base;
        bus.job_i_prec   = j.i_prec;
        bus.job_w_prec   = j.w_prec;
        bus.job_use_bias = j.use_bias;
        bus.job_vld      = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.job_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, "_job_rdy"}, PSUM_W'(bus.job_rdy), 1);
    endtask

    task automatic apply_stimulus(input job_t j, input string tag);
        int k = 1, n_rd = 0, n_vld = 0, n_bias = 0, n_flush = 0;
        int first_vld = -1, last_vld = -1, bias_k = -1, flush_k = -1, res_k = -1;
        int addr_err = 0, prec_err = 0, busy_err = 0, stable_err = 0, exp_k, limit;
        int n = j.len;
        logic [ADDR_W-1:0] ea, ew;
        logic [PSUM_W-1:0] psum0;
        logic              err0;

        wait_ready(tag);
        drive_job(j);
        @(posedge clk);
        sb_q.push_back('{psum: j.exp_psum, err: j.exp_err});
        @(negedge clk);
        bus.job_vld = 1'b0;
        limit = n + TMO + 20;

        while (k <= limit && res_k < 0) begin
            if (core_i_prec !== j.i_prec || core_w_prec !== j.w_prec) prec_err++;
            if (bus.job_rdy !== 1'b0 || busy !== 1'b1) busy_err++;
            if (act_rd_en) begin
                ea = j.act_base + ADDR_W'(n_rd);
                ew = j.wgt_base + ADDR_W'(n_rd);
                if (act_rd_addr !== ea || wgt_rd_addr !== ew || wgt_rd_en !== 1'b1) addr_err++;
                n_rd++;
            end else if (wgt_rd_en !== 1'b0) begin
                addr_err++;
            end
            if (core_vld) begin
                if (first_vld < 0) first_vld = k;
                last_vld = k;
                n_vld++;
            end
            if (core_sel_bias) begin n_bias++; bias_k = k; end
            if (core_flush) begin n_flush++; flush_k = k; end
            if (bus.res_vld) res_k = k;

            // A job_vld and a stray core_done while streaming must both be ignored
            bus.job_vld    = j.poke && (k == 2);
            bus.job_i_prec = ~j.i_prec;
            bus.job_len    = '0;
            core_done = (flush_k > 0 && k == flush_k + j.done_dly) || (j.poke && k == 2);
            core_psum = (j.poke && k == 2) ? ~j.psum : j.psum;
            if (res_k < 0) begin
                @(negedge clk);
                k++;
            end
        end

        if (n == 0) exp_k = 1;
        else if (j.done_dly >= 1 && j.done_dly <= TMO) exp_k = n + 3 + j.done_dly;
        else exp_k = n + 3 + TMO;

        check_output({tag, "_res_latency"}, PSUM_W'(res_k), PSUM_W'(exp_k));
        check_output({tag, "_rd_count"}, PSUM_W'(n_rd), PSUM_W'(n));
        check_output({tag, "_addr_errs"}, PSUM_W'(addr_err), 0);
        check_output({tag, "_vld_count"}, PSUM_W'(n_vld), PSUM_W'(n));
        check_output({tag, "_vld_first"}, PSUM_W'(first_vld), PSUM_W'(n ? 2 : -1));
        check_output({tag, "_vld_last"}, PSUM_W'(last_vld), PSUM_W'(n ? n + 1 : -1));
        check_output({tag, "_bias_count"}, PSUM_W'(n_bias), PSUM_W'((j.use_bias && n != 0) ? 1 : 0));
        check_output({tag, "_bias_cycle"}, PSUM_W'(bias_k), PSUM_W'((j.use_bias && n != 0) ? 2 : -1));
        check_output({tag, "_flush_count"}, PSUM_W'(n_flush), PSUM_W'(n ? 1 : 0));
        check_output({tag, "_flush_cycle"}, PSUM_W'(flush_k), PSUM_W'(n ? n + 2 : -1));
        check_output({tag, "_prec_errs"}, PSUM_W'(prec_err), 0);
        check_output({tag, "_busy_errs"}, PSUM_W'(busy_err), 0);
        check_output({tag, "_res_psum"}, bus.res_psum, j.exp_psum);
        check_output({tag, "_res_err"}, PSUM_W'(bus.res_err), PSUM_W'(j.exp_err));

        psum0 = bus.res_psum;
        err0  = bus.res_err;
        for (int h = 0; h < j.hold; h++) begin
            @(negedge clk);
            k++;
            core_done = (flush_k > 0 && k == flush_k + j.done_dly);
            core_psum = j.psum;
            if (bus.res_psum !== psum0 || bus.res_err !== err0 || bus.res_vld !== 1'b1 ||
                bus.job_rdy !== 1'b0) stable_err++;
        end
        check_output({tag, "_hold_stable_errs"}, PSUM_W'(stable_err), 0);

        core_done   = 1'b0;
        bus.res_rdy = 1'b1;
        @(negedge clk);
        bus.res_rdy = 1'b0;
        check_output({tag, "_rdy_after_hs"}, PSUM_W'({bus.job_rdy, bus.res_vld}), PSUM_W'(2'b10));
    endtask

    initial begin
        bus.job_vld = 1'b0; bus.job_len = '0; bus.job_act_base = '0; bus.job_wgt_base = '0;
        bus.job_i_prec = '0; bus.job_w_prec = '0; bus.job_use_bias = 1'b0; bus.res_rdy = 1'b0;
        core_done = 1'b0; core_psum = '0;

        jobs[0] = mk(4, 'h010, 'h200, PREC_8B, PREC_4B, 1'b1, 3, {4{16'hA5C3}}, 5, 1'b1, 1'b0, {4{16'hA5C3}});
        jobs[1] = mk(0, 'h123, 'h045, PREC_4B, PREC_8B, 1'b1, 3, 64'h1234, 2, 1'b0, 1'b1, '0);
        jobs[2] = mk(4, 'h3FE, 'h3FF, PREC_2B, PREC_8B, 1'b0, 1, 64'h0123_4567_89AB_CDEF, 0, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF);
        jobs[3] = mk(1, 'h000, 'h3FF, PREC_4B, PREC_4B, 1'b1, 2, 64'hDEAD_BEEF_0BAD_F00D, 1, 1'b0, 1'b0, 64'hDEAD_BEEF_0BAD_F00D);
        jobs[4] = mk(2, 'h055, 'h0AA, PREC_8B, PREC_2B, 1'b0, TMO + 1, 64'h7777_8888, 3, 1'b0, 1'b1, '0);
        jobs[5] = mk(3, 'h100, 'h101, PREC_2B, PREC_2B, 1'b1, TMO, 64'h5A5A, 0, 1'b0, 1'b0, 64'h5A5A);
        jobs[6] = mk(2, 'h020, 'h030, PREC_4B, PREC_2B, 1'b0, 0, 64'h9999, 0, 1'b0, 1'b1, '0);
        jobs[7] = mk(3, 'h3FF, 'h001, PREC_8B, PREC_4B, 1'b1, 4, 64'hCAFE_F00D, 2, 1'b0, 1'b0, 64'hCAFE_F00D);

        #3 rst_n = 1'b0;
        #4 check_reset_state("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) apply_stimulus(jobs[i], $sformatf("job%0d", i));

        // Abort a running job with reset: no flush and no result may follow
        wait_ready("abort");
        drive_job(mk(6, 'h080, 'h090, PREC_8B, PREC_4B, 1'b1, 3, '0, 0, 1'b0, 1'b0, '0));
        @(posedge clk);
        @(negedge clk);
        bus.job_vld = 1'b0;
        repeat (2) @(negedge clk);
        check_output("abort_in_run", PSUM_W'({act_rd_en, busy}), PSUM_W'(2'b11));
        rst_n = 1'b0;
        #1 check_reset_state("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_output("abort_no_flush", PSUM_W'({core_flush, bus.res_vld, busy}), '0);

        apply_stimulus(jobs[7], "after_abort");

        repeat (3) @(negedge clk);
        check_output("sb_empty", PSUM_W'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
